// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC register, prefetch queue and valid/ready handoff to decode.
// Optional fetch address bounds checking is enabled by defining FETCH_BOUNDS_EN.
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          MEM_WORDS   = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  // 33 bits so a memory of exactly 2^30 words still compares correctly
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

  state_t state, state_nxt;
  logic [31:0] pc;
  logic [QUEUE_DEPTH-1:0][31:0] q_pc, q_inst;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic pop, room, want, bad, push, oob;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_inst  = q_inst[head];
  assign out_pc    = q_pc[head];

  // A redirect discards the handshake and any push in the same cycle
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign room = (count < DEPTH_C) || pop;
  assign want = (state == FETCH) && room && !redirect_valid;
  assign oob  = (pc[1:0] != 2'b00) || ({1'b0, pc} >= LIMIT);

`ifdef FETCH_BOUNDS_EN
  assign bad = want && oob;
`else
  logic unused_bounds;
  assign unused_bounds = oob;
  assign bad = 1'b0;
`endif

  assign push = want && !bad;

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = fetch_en ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE:    if (fetch_en) state_nxt = FETCH;
        FETCH:   if (bad) state_nxt = FAULT;
                 else if (!fetch_en) state_nxt = IDLE;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pc   <= '0;
      q_inst <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pc[tail]   <= pc;
        q_inst[tail] <= imem_data;
        tail         <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_BOUNDS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      fault    <= 1'b0;
    end else if (bad) begin
      fault    <= 1'b1;
      fault_pc <= pc;
    end
  end
`else
  assign fault    = 1'b0;
  assign fault_pc = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: cycle table for the main flow plus a delivery scoreboard.
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_inst, out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int vecs = 0;
  int miss = 0;
  int pops = 0;
  logic [31:0] exp_q[$];

  fetch_controller #(.RESET_PC(32'h0), .QUEUE_DEPTH(2), .MEM_WORDS(65536)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  // Words 0..3 read 0x11, 0x22, 0x33, 0x44; the pattern continues beyond
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h11 * {2'b00, a[31:2]} + 32'h11;
  endfunction
  assign imem_data = memf(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] target);
    exp_q.delete();
    for (int k = 0; k < 48; k++) exp_q.push_back(target + 32'(4 * k));
  endtask

  // Scoreboard: every accepted instruction must be the next one of the current stream
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid) sb_restart(redirect_pc);
      else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", out_pc, 32'hxxxx_xxxx);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("sb_pc", out_pc, e);
          chk("sb_inst", out_inst, memf(e));
          pops++;
        end
      end
    end
  end

  typedef struct {
    logic        fe, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, eaddr;
  } vec_t;
  vec_t tv[27];

  function automatic vec_t mk(input logic fe, rdy, rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, eaddr);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic redirect(input logic [31:0] t);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = t;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input string name, input int n);
    int p0;
    p0 = pops;
    for (int c = 0; c < 30 && pops < p0 + n; c++) @(posedge clk);
    chk(name, 32'(pops - p0 >= n), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_inst"}, out_inst, 32'h0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_fault_pc"}, fault_pc, 32'h0);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    sb_restart(32'h0);
    fetch_en = 1'b1; out_ready = 1'b1;
    rst_n = 1'b1;
    wait_pops({tag, "_resume"}, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tv[0]  = mk(1,1,0,0,       0,0,     32'h00);
    tv[1]  = mk(1,1,0,0,       0,0,     32'h00);
    tv[2]  = mk(1,1,0,0,       1,32'h00,32'h04);
    tv[3]  = mk(1,1,0,0,       1,32'h04,32'h08);
    tv[4]  = mk(1,1,0,0,       1,32'h08,32'h0C);
    tv[5]  = mk(1,1,0,0,       1,32'h0C,32'h10);
    tv[6]  = mk(1,0,0,0,       1,32'h10,32'h14);
    tv[7]  = mk(1,0,0,0,       1,32'h10,32'h18);
    tv[8]  = mk(1,0,0,0,       1,32'h10,32'h18);
    tv[9]  = mk(1,0,0,0,       1,32'h10,32'h18);
    tv[10] = mk(1,0,0,0,       1,32'h10,32'h18);
    tv[11] = mk(1,1,0,0,       1,32'h10,32'h18);
    tv[12] = mk(1,1,0,0,       1,32'h14,32'h1C);
    tv[13] = mk(1,1,0,0,       1,32'h18,32'h20);
    tv[14] = mk(1,1,1,32'h40,  1,32'h1C,32'h24);
    tv[15] = mk(1,1,0,0,       0,0,     32'h40);
    tv[16] = mk(1,1,0,0,       1,32'h40,32'h44);
    tv[17] = mk(0,1,0,0,       1,32'h44,32'h48);
    tv[18] = mk(0,1,0,0,       1,32'h48,32'h4C);
    tv[19] = mk(0,1,0,0,       0,0,     32'h4C);
    tv[20] = mk(1,0,0,0,       0,0,     32'h4C);
    tv[21] = mk(1,0,0,0,       0,0,     32'h4C);
    tv[22] = mk(0,1,1,32'h100, 1,32'h4C,32'h50);
    tv[23] = mk(0,1,0,0,       0,0,     32'h100);
    tv[24] = mk(1,1,0,0,       0,0,     32'h100);
    tv[25] = mk(1,1,0,0,       0,0,     32'h100);
    tv[26] = mk(1,1,0,0,       1,32'h100,32'h104);

    #3;
    check_reset_vals("reset");
    sb_restart(32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      fetch_en = tv[i].fe; out_ready = tv[i].rdy;
      redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].eaddr);
      if (tv[i].ev) begin
        chk($sformatf("v%0d_pc", i), out_pc, tv[i].epc);
        chk($sformatf("v%0d_inst", i), out_inst, memf(tv[i].epc));
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    fetch_en = 1'b1; out_ready = 1'b1;

`ifdef FETCH_BOUNDS_EN
    redirect(32'h0004_0000);
    @(negedge clk);
    @(negedge clk);
    chk("oob_fault", 32'(fault), 32'd1);
    chk("oob_fault_pc", fault_pc, 32'h0004_0000);
    repeat (3) @(negedge clk);
    chk("oob_no_push", 32'(out_valid), 32'd0);
    chk("oob_pc_held", imem_addr, 32'h0004_0000);
    redirect(32'h0);
    @(negedge clk);
    chk("clear_fault", 32'(fault), 32'd0);
    wait_pops("resume_after_fault", 2);
    redirect(32'h2);
    @(negedge clk);
    @(negedge clk);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h2);
    mid_reset("fault_reset");
`else
    redirect(32'hFFFF_FFF8);
    wait_pops("wrap_deliveries", 4);
    chk("fault_tied", 32'(fault), 32'd0);
    mid_reset("run_reset");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the instruction memory for the single-cycle core: holds the program counter, drives word-aligned fetch addresses into the combinational-read instruction memory, and buffers fetched words in a small prefetch queue. Decode consumes the queue over a valid/ready handshake. The block sits between the instruction memory and the decode stage and absorbs redirects (branch/jump) and stalls.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- QUEUE_DEPTH, 2, prefetch queue entries; power of two, ≥ 2
- MEM_WORDS, 65536, instruction memory size in 32-bit words; the valid byte range is 0 .. 4*MEM_WORDS-1

Ports:

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  allows fetching; low holds the PC
- imem_addr  out  32  byte address to instruction memory; always equals the PC register
- imem_data  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  one-cycle pulse that loads a new PC
- redirect_pc  in  32  target of the redirect
- out_valid  out  1  head queue entry valid
- out_ready  in  1  decode accepts the head entry
- out_inst  out  32  head instruction
- out_pc  out  32  PC of the head instruction
- fault  out  1  sticky fetch fault
- fault_pc  out  32  PC that caused the fault

## Operation

- State machine states: IDLE, FETCH, FAULT.
  - IDLE → FETCH when fetch_en=1.
  - FETCH → IDLE when fetch_en=0.
  - FETCH → FAULT on a bounds violation (see Configuration).
  - FAULT is left only through a redirect, which goes to FETCH if fetch_en=1, otherwise IDLE.
- Push: in FETCH, if the queue has room (count < QUEUE_DEPTH, or count == QUEUE_DEPTH and a pop happens in the same cycle), then {pc, imem_data} is written at the tail and pc ← pc + 4.
- PC increment is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Pop: occurs when out_valid && out_ready. The head advances and count decrements.
- When a push and a pop happen in the same cycle, count is unchanged.
- out_valid = (count ≠ 0). out_inst and out_pc are taken from the head entry and are stable while out_valid=1 and out_ready=0.
- Redirect has top priority over all other activity:
  - Queue is flushed (count ← 0).
  - pc ← redirect_pc.
  - fault is cleared.
  - No push occurs that cycle, and any pop that cycle is discarded.
- Redirect is accepted in every state.
- IDLE and FAULT hold the PC and perform no pushes. Pops continue, so the queue drains.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); queued entries are lost.

## Timing

- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC
  - state = IDLE, count = 0, out_valid = 0
  - out_inst = 0, out_pc = 0 (queue storage is cleared)
  - fault = 0, fault_pc = 0
- Fetch latency: the PC is presented during cycle N and the word is pushed at the edge ending cycle N. out_valid is high in cycle N+1.
- Throughput: one instruction per cycle with out_ready held high.
- Redirect latency: redirect pulse in cycle N → out_valid=0 in N+1 → first target instruction valid in N+2.
- Backpressure: with out_ready=0, the queue fills after QUEUE_DEPTH pushes, then the PC holds. imem_addr shows the next unfetched address.

## Configuration

- FETCH_BOUNDS_EN defined:
  - Before each push, the PC is checked for two conditions: pc[1:0] ≠ 0 (misaligned), or pc ≥ 4*MEM_WORDS (out of range).
  - On violation:
    - no push occurs
    - fault ← 1
    - fault_pc ← pc
    - state → FAULT
  - Entries already queued remain poppable.
- FETCH_BOUNDS_EN undefined:
  - No check is performed; addresses pass through unchanged.
  - fault and fault_pc are tied to 0, and FAULT is unreachable.

## Test plan

- Reset, then fetch_en=1, out_ready=1, with memory words 0..3 = 0x11, 0x22, 0x33, 0x44 → out_pc 0, 4, 8, C with matching out_inst on consecutive cycles; first valid one cycle after the first edge.
- out_ready=0 for 5 cycles → exactly QUEUE_DEPTH=2 entries held (PC 0, 4), imem_addr stays 8, head stable. Release out_ready → PC 0, 4, 8 delivered in order with no loss or duplication.
- Redirect to 0x40 while the queue holds 2 entries and out_ready=1 → the next cycle has out_valid=0, the following cycle has out_pc=0x40; no stale entry is ever delivered.
- Redirect and pop in the same cycle, with fetch_en dropped in the same cycle as a push → redirect wins and the pop is discarded. Dropping fetch_en lets the in-flight push complete, then the PC holds.
- With FETCH_BOUNDS_EN defined, redirect to 0x0004_0000 (MEM_WORDS=65536) → fault=1, fault_pc=0x0004_0000, no pushes. A redirect to 0x0 clears fault and fetching resumes.
- With FETCH_BOUNDS_EN defined, redirect to 0x2 → fault with fault_pc=0x2. Assert rst_n low mid-fault → every output returns to its reset value within the same cycle.
